fifo_pop_ctrl: RTL and testbench
================================

// Module: fifo_pop_ctrl
// PURPOSE
//  Drain stage directly downstream of the FIFO. Issues pop when the FIFO reports pndng,
//  captures dato_out, and re-presents words on a valid/ready master port through a
//  3-entry skid buffer. Full throughput (1 word/clk); no combinational path m_ready->pop.
//  Counts delivered words for the scoreboard/status path.
// PARAMETERS
//  width  16  data width; must match FIFO width
//  CNT_W  16  width of delivered-word counter
// PORTS
//  clk       in   1      clock; all state on posedge
//  rst       in   1      reset, synchronous, active-low (0 = reset)
//  en        in   1      drain enable; 0 blocks new pops only
//  pndng     in   1      FIFO not-empty; updated on the same edge that samples pop
//  pop       out  1      FIFO read strobe, one word per cycle high
//  dato_out  in   width  FIFO read data, valid the cycle after pop
//  m_valid   out  1      m_data holds a word
//  m_ready   in   1      consumer accepts word when m_valid&&m_ready
//  m_data    out  width  output word (buffer head)
//  count     out  CNT_W  words delivered since reset, wraps mod 2^CNT_W
//  busy      out  1      read in flight or buffer non-empty
// BEHAVIOUR
//  State: inflight (1b, pop issued last cycle), occ (0..3), 3-entry circular buffer
//   (wr_ptr/rd_ptr 2b, wrap 2->0), count.
//  Reset (rst==0 at posedge): inflight=0, occ=0, ptrs=0, buffer=0, count=0.
//   Outputs: pop=0 (gated by rst combinationally), m_valid=0, m_data=0, count=0, busy=0.
//   Reset mid-operation discards the in-flight word and all buffered words.
//  pop = rst && en && pndng && (occ + inflight <= 2); registered state only.
//  Capture: inflight==1 -> dato_out written at wr_ptr this cycle; wr_ptr++, occ++.
//  Output: m_valid = (occ!=0); m_data = buf[rd_ptr].
//   Handshake m_valid&&m_ready -> rd_ptr++, occ--, count++.
//  Capture and handshake in the same cycle: occ unchanged, both ptrs advance.
//  Stability: while m_valid && !m_ready, m_valid and m_data hold.
//  Latency: pop at cycle t -> word captured at end of t+1 -> m_valid at t+2 (if empty).
//  Full: occ+inflight==3 -> pop=0 until a handshake lowers the sum.
//   Overflow impossible; assert occ<=3.
//  Empty: pndng=0 -> pop=0; buffered words still delivered.
//  en=0: no new pops; in-flight word still captured; buffer drains normally.
//  count wraps 2^CNT_W-1 -> 0 silently. busy = inflight || (occ!=0).
//  Ordering: words leave in pop order; no loss, no duplication.
// TESTING
//  1 rst=0 3 clks, en=1, pndng=1 -> pop=0, m_valid=0, count=0, busy=0 every cycle.
//  2 FIFO holds 0x0001..0x0008, en=1, m_ready=1
//    -> pop high 8 consecutive clks; m_valid from 2 clks after first pop, 8 clks, data in order; count=8.
//  3 Same load, m_ready=0 -> exactly 3 pops then pop=0; m_data holds 0x0001;
//    raise m_ready -> 0x0001..0x0008 in order, count=8.
//  4 en=0 the cycle after the 2nd pop -> no 3rd pop; 2 words delivered;
//    busy=0 after drain; pndng stays 1.
//  5 CNT_W=4, 17 words streamed -> count=1 after the last handshake.
//  6 occ=3, m_ready=0, pulse rst=0 1 clk -> next cycle m_valid=0, count=0;
//    first word after release is the next FIFO word.

Source files
------------

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: drains a FIFO into a 3-entry skid buffer behind a valid/ready master port.
// Pop is decided from registered occupancy only, so m_ready never reaches pop combinationally.
module fifo_pop_ctrl #(
    parameter int width = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pndng,
    output logic             pop,
    input  logic [width-1:0] dato_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [width-1:0] m_data,
    output logic [CNT_W-1:0] count,
    output logic             busy
);
    logic             inflight_q;
    logic [1:0]       occ_q, occ_d, wr_q, wr_d, rd_q, rd_d;
    logic [width-1:0] buf_q [3];
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       load;
    logic             hs;

    // Reserve a slot for the word already in flight so a pop can never overflow the buffer.
    assign load    = {1'b0, occ_q} + {2'b0, inflight_q};
    assign pop     = rst && en && pndng && (load <= 3'd2);
    assign m_valid = occ_q != 2'd0;
    assign m_data  = buf_q[rd_q];
    assign hs      = m_valid && m_ready;
    assign count   = count_q;
    assign busy    = inflight_q || m_valid;

    always_comb begin
        wr_d    = inflight_q ? (wr_q == 2'd2 ? 2'd0 : wr_q + 2'd1) : wr_q;
        rd_d    = hs ? (rd_q == 2'd2 ? 2'd0 : rd_q + 2'd1) : rd_q;
        occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, hs};
        count_d = count_q + CNT_W'(hs);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_q       <= 2'd0;
            rd_q       <= 2'd0;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            inflight_q <= pop;
            occ_q      <= occ_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            if (inflight_q) buf_q[wr_q] <= dato_out;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) load <= 3'd3);
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed checks of the drain stage against a behavioural FIFO.
module tb_fifo_pop_ctrl;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, pndng = 1'b0, m_ready = 1'b0;
    logic [15:0] dato_out = '0;
    logic        pop, m_valid, busy, pop4, m_valid4, busy4;
    logic [15:0] m_data, m_data4, count;
    logic [3:0]  count4;
    int          errors = 0, checks = 0, cyc = 0;
    int          pop_cyc[$], got_cyc[$];
    logic [15:0] got[$], fq[$];

    fifo_pop_ctrl #(.width(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng), .pop(pop), .dato_out(dato_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count), .busy(busy));

    fifo_pop_ctrl #(.width(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .pndng(pndng), .pop(pop4), .dato_out(dato_out),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .count(count4), .busy(busy4));

    always #5 clk = ~clk;

    // FIFO read data appears the cycle after pop
    always @(posedge clk) if (pop) dato_out <= fq.pop_front();

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            pndng = fq.size() != 0;
            #1;
            if (pop) pop_cyc.push_back(cyc);
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        pndng = fq.size() != 0;
    endtask

    task automatic reset_load(input int n);
        rst = 1'b0;
        fq.delete();
        pop_cyc.delete();
        got_cyc.delete();
        got.delete();
        cyc = 0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= n; k++) fq.push_back(16'(k));
        rst = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) fq.push_back(16'(k));
        rst = 1'b0; en = 1'b1; pndng = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t1_pop%0d", c), pop, 0);
            chk($sformatf("t1_valid%0d", c), m_valid, 0);
            chk($sformatf("t1_count%0d", c), count, 0);
            chk($sformatf("t1_busy%0d", c), busy, 0);
            @(posedge clk);
            #1;
        end

        reset_load(8);
        m_ready = 1'b1; en = 1'b1;
        run(14);
        chk("t2_npop", pop_cyc.size(), 8);
        chk("t2_popspan", pop_cyc[7] - pop_cyc[0], 7);
        chk("t2_latency", got_cyc[0] - pop_cyc[0], 2);
        chk("t2_gotspan", got_cyc[7] - got_cyc[0], 7);
        chk("t2_ngot", got.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_data%0d", i), got[i], i + 1);
        chk("t2_count", count, 8);
        chk("t2_busy", busy, 0);

        reset_load(8);
        m_ready = 1'b0;
        run(6);
        chk("t3_npop", pop_cyc.size(), 3);
        chk("t3_popnow", pop, 0);
        chk("t3_valid", m_valid, 1);
        chk("t3_hold", m_data, 16'h0001);
        m_ready = 1'b1;
        run(14);
        chk("t3_ngot", got.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_data%0d", i), got[i], i + 1);
        chk("t3_count", count, 8);

        reset_load(8);
        m_ready = 1'b1;
        run(2);
        en = 1'b0;
        run(8);
        chk("t4_npop", pop_cyc.size(), 2);
        chk("t4_ngot", got.size(), 2);
        chk("t4_data1", got[1], 16'h0002);
        chk("t4_count", count, 2);
        chk("t4_busy", busy, 0);
        chk("t4_pndng", pndng, 1);
        en = 1'b1;

        reset_load(17);
        m_ready = 1'b1;
        run(25);
        chk("t5_count4", count4, 1);
        chk("t5_count16", count, 17);
        chk("t5_ngot", got.size(), 17);
        chk("t5_last", got[16], 16'h0011);

        reset_load(8);
        m_ready = 1'b0;
        run(5);
        chk("t6_full_valid", m_valid, 1);
        chk("t6_full_pop", pop, 0);
        chk("t6_npop", pop_cyc.size(), 3);
        rst = 1'b0;
        #1;
        chk("t6_rst_pop", pop, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t6_valid", m_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_busy", busy, 0);
        got.delete();
        m_ready = 1'b1;
        run(12);
        chk("t6_first", got[0], 16'h0004);
        chk("t6_ngot", got.size(), 5);
        chk("t6_count_after", count, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
